// File: rtl/or_tree_pipe.sv
// Pipelined OR-reduction tree: LANES words of WIDTH bits -> bitwise OR plus any-bit-set flag.
// Optional running-OR accumulator (acc_clr/acc_word) when OR_TREE_STICKY_EN is defined.
module or_tree_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*LANES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_word,
    output logic                   out_any
`ifdef OR_TREE_STICKY_EN
    ,
    input  logic                   acc_clr,
    output logic [WIDTH-1:0]       acc_word
`endif
);

    localparam int unsigned LEVELS    = $clog2(LANES);
    localparam int unsigned PAD_LANES = 2 ** LEVELS;
    localparam int unsigned NODES     = PAD_LANES - 1;
    localparam int unsigned ALL_WORDS = PAD_LANES + NODES;

    // Word offset of level l's source words inside tree_c (level 0 reads the padded input).
    function automatic int unsigned level_base(input int unsigned l);
        return (2 * PAD_LANES) - ((2 * PAD_LANES) >> l);
    endfunction

    logic [PAD_LANES*WIDTH-1:0] in_pad_c;
    logic [NODES*WIDTH-1:0]     node_q;
    logic [ALL_WORDS*WIDTH-1:0] tree_c;
    logic [LEVELS-1:0]          valid_q;
    logic [LEVELS:0]            src_valid_c;
    logic [LEVELS:0]            ready_c;

    // Missing lanes are zero, so an odd trailing word passes through its OR unchanged.
    assign in_pad_c    = (PAD_LANES*WIDTH)'(in_data);
    assign tree_c      = {node_q, in_pad_c};
    assign src_valid_c = {valid_q, in_valid};

    // Stall chain: an empty stage always accepts, a full one only if downstream moves.
    always_comb begin
        ready_c         = '0;
        ready_c[LEVELS] = out_ready;
        for (int l = int'(LEVELS) - 1; l >= 0; l--) begin
            ready_c[l] = !valid_q[l] || ready_c[l+1];
        end
    end

    // Tree stages: valid follows its source whenever ready; data loads only on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            node_q  <= '0;
        end else begin
            for (int unsigned l = 0; l < LEVELS; l++) begin
                if (ready_c[l]) begin
                    valid_q[l] <= src_valid_c[l];
                    if (src_valid_c[l]) begin
                        for (int unsigned j = 0; j < (PAD_LANES >> (l + 1)); j++) begin
                            node_q[(level_base(l + 1) - PAD_LANES + j)*WIDTH +: WIDTH] <=
                                tree_c[(level_base(l) + 2*j)*WIDTH +: WIDTH] |
                                tree_c[(level_base(l) + 2*j + 1)*WIDTH +: WIDTH];
                        end
                    end
                end
            end
        end
    end

    assign in_ready  = ready_c[0];
    assign out_valid = src_valid_c[LEVELS];
    assign out_word  = tree_c[(ALL_WORDS-1)*WIDTH +: WIDTH];
    assign out_any   = |out_word;

`ifdef OR_TREE_STICKY_EN
    logic [WIDTH-1:0] acc_q;
    logic             xfer_c;

    assign xfer_c = out_valid && out_ready;

    // Clear takes priority, then the word transferred in the same cycle is OR'd in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= xfer_c ? out_word : '0;
        end else if (xfer_c) begin
            acc_q <= acc_q | out_word;
        end
    end

    assign acc_word = acc_q;
`endif

endmodule
